// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and FSM encoding for the pipeline stall controller
package pipe_ctrl_pkg;
  localparam int REG_W         = 5;
  localparam int SRAM_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_raw_hazard_detect.sv
// rtl/pipe_stall_ctrl_raw_hazard_detect.sv - combinational RAW hazard detect (NO_FWD_STALL_EN widens it)
module raw_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hz
);
  logic exe_match;
  logic mem_match;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign exe_match = (exe_dest != '0) &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
  assign mem_match = (mem_dest != '0) &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

`ifdef NO_FWD_STALL_EN
  assign hz = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
`else
  logic unused_mem_match;
  assign unused_mem_match = mem_match & mem_wb_en;
  assign hz = exe_wb_en && exe_mem_r_en && exe_match;
`endif
endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with SRAM wait-state FSM; option NO_FWD_STALL_EN
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             branch_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             load_fwd_stall,
  output logic             super_stall,
  output logic             mem_done
);
  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             hz;
  logic             req;

  raw_hazard_detect u_hz (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hz           (hz)
  );

  assign req = mem_r_en | mem_w_en;

  // IDLE freezes combinationally on the request cycle, then BUSY covers SRAM_WAIT-1 more.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (req) begin
            cnt   <= CNT_W'(SRAM_WAIT - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign super_stall    = ~rst & ((state == BUSY) | ((state == IDLE) & req));
  assign mem_done       = ~rst & done_q;
  assign load_fwd_stall = ~rst & hz & ~super_stall & ~branch_taken;
  assign flush_if_id    = ~rst & branch_taken & ~super_stall;
  assign flush_id_exe   = flush_if_id | load_fwd_stall;
  assign freeze_pc      = super_stall | load_fwd_stall;
  assign freeze_if_id   = super_stall | load_fwd_stall;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl with reference model
module tb_pipe_stall_ctrl;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_r_en, mem_w_en, branch_taken;
  logic       freeze_pc, freeze_if_id, flush_if_id, flush_id_exe;
  logic       load_fwd_stall, super_stall, mem_done;

  int checks = 0;
  int errors = 0;
  int m_left = 0;
  bit m_done = 0;
  logic obs_ss, obs_md, obs_lfs;

  pipe_stall_ctrl #(.SRAM_WAIT(SW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_taken(branch_taken),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .load_fwd_stall(load_fwd_stall), .super_stall(super_stall), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0b expected=%0b", tag, name, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] d);
    return (d != 0) && (d == id_src1 || (id_two_src && d == id_src2));
  endfunction

  function automatic bit model_hz();
    bit h;
    h = exe_wb_en && exe_mem_r_en && reads(exe_dest);
`ifdef NO_FWD_STALL_EN
    h = h || (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
`endif
    return h;
  endfunction

  task automatic clear_inputs();
    id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; mem_r_en = 0; mem_w_en = 0;
    branch_taken = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step(input string tag);
    bit req, e_ss, e_md, e_lfs, e_fif;
    #1;
    req = mem_r_en || mem_w_en;
    if (rst) begin
      e_ss = 0; e_md = 0;
    end else if (m_done) begin
      e_ss = 0; e_md = 1;
    end else if (m_left > 0) begin
      e_ss = 1; e_md = 0;
    end else begin
      e_ss = req; e_md = 0;
    end
    e_lfs = !rst && model_hz() && !e_ss && !branch_taken;
    e_fif = !rst && branch_taken && !e_ss;
    obs_ss = super_stall; obs_md = mem_done; obs_lfs = load_fwd_stall;
    check(tag, "super_stall", super_stall, e_ss);
    check(tag, "mem_done", mem_done, e_md);
    check(tag, "load_fwd_stall", load_fwd_stall, e_lfs);
    check(tag, "flush_if_id", flush_if_id, e_fif);
    check(tag, "flush_id_exe", flush_id_exe, e_fif || e_lfs);
    check(tag, "freeze_pc", freeze_pc, e_ss || e_lfs);
    check(tag, "freeze_if_id", freeze_if_id, e_ss || e_lfs);
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (req) begin
      m_left = SW - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int ss_cnt;
    int done_at;
    clear_inputs();
    rst = 1;
    @(negedge clk);
    step("reset");
    step("reset");
    rst = 0;
    step("post_reset");

    // load-use on src1
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
    step("load_use");
    check("load_use", "lfs_const", obs_lfs, 1'b1);
    clear_inputs();
    step("load_use_after");

    // register 0 guard
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 0; id_src1 = 0;
    step("r0_guard");
    check("r0_guard", "lfs_const", obs_lfs, 1'b0);
    clear_inputs();

    // SRAM load held: freeze for SW cycles, done pulse on cycle SW+1
    mem_r_en = 1;
    ss_cnt = 0; done_at = 0;
    for (int c = 1; c <= SW + 1; c++) begin
      step("sram_load");
      if (obs_ss) ss_cnt++;
      if (obs_md) done_at = c;
    end
    check("sram_load", "freeze_len", 1'(ss_cnt == SW), 1'b1);
    check("sram_load", "done_cycle", 1'(done_at == SW + 1), 1'b1);
    mem_r_en = 0;
    step("sram_idle");

    // branch with load-use hazard: flush wins
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 9; id_src2 = 9; id_two_src = 1;
    branch_taken = 1;
    step("br_hz");
    clear_inputs();

    // branch during a store freeze: suppressed until DONE
    mem_w_en = 1; branch_taken = 1;
    step("br_stall");
    mem_w_en = 0;
    for (int c = 0; c < SW + 1; c++) step("br_stall");
    clear_inputs();
    step("br_stall_end");

    // reset in the second BUSY cycle
    mem_r_en = 1;
    step("rst_mid");
    mem_r_en = 0;
    step("rst_mid");
    rst = 1;
    step("rst_mid");
    rst = 0;
    for (int c = 0; c < SW + 1; c++) step("rst_after");

    // MEM-stage writer on src2 stalls only without forwarding
    mem_wb_en = 1; mem_dest = 7; id_src2 = 7; id_two_src = 1;
    step("mem_writer");
`ifdef NO_FWD_STALL_EN
    check("mem_writer", "lfs_const", obs_lfs, 1'b1);
`else
    check("mem_writer", "lfs_const", obs_lfs, 1'b0);
`endif
    clear_inputs();

    for (int i = 0; i < 600; i++) begin
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      mem_r_en     = ($urandom_range(0, 9) == 0);
      mem_w_en     = ($urandom_range(0, 14) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      rst          = ($urandom_range(0, 59) == 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
